// File: rtl/aes_axis_blk_rx.sv
// AXI4-Stream slave front end of the AES core: packs WORDS_PER_BLK words into one big-endian block.
// Optional macro AES_AXIS_RX_BSWAP_EN byte-reverses each accepted word before placement.
module aes_axis_blk_rx #(
   parameter int WORD_W        = 32,
   parameter int WORDS_PER_BLK = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [WORD_W-1:0]               s_axis_tdata,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [WORD_W*WORDS_PER_BLK-1:0] blk_data,
   output logic                            blk_last,
   output logic                            blk_valid,
   input  logic                            blk_ready,
   output logic                            frame_err,
   output logic [31:0]                     blk_cnt
);

   localparam int BLK_W = WORD_W * WORDS_PER_BLK;
   localparam int CNT_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLK - 1);

   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              beat;
   logic              final_beat;
   logic              early_last;
   logic              drain;
   logic [WORD_W-1:0] word_in;
   logic [BLK_W-1:0]  asm_q;
   logic [BLK_W-1:0]  asm_next;

`ifdef AES_AXIS_RX_BSWAP_EN
   function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int b = 0; b < WORD_W / 8; b++) begin
         r[b*8 +: 8] = w[WORD_W-8-b*8 +: 8];
      end
      return r;
   endfunction

   assign word_in = byte_swap(s_axis_tdata);
`else
   assign word_in = s_axis_tdata;
`endif

   // A word may enter in the same cycle the pending block drains, so ready follows blk_ready combinationally.
   assign s_axis_tready = !reset && (!blk_valid || blk_ready);

   // State register: the word counter is the COLLECT(0..N-1) state.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default first, otherwise a latch is inferred.
      cnt_d = cnt_q;
      if (beat) begin
         cnt_d = (final_beat || s_axis_tlast) ? '0 : cnt_q + 1'b1;
      end
   end

   // Output / decode logic: beat qualification and word placement into the assembly image.
   always_comb begin
      beat       = s_axis_tvalid && s_axis_tready;
      final_beat = beat && (cnt_q == LAST_IDX);
      early_last = beat && s_axis_tlast && (cnt_q != LAST_IDX);
      drain      = blk_valid && blk_ready;
      asm_next   = asm_q;
      for (int k = 0; k < WORDS_PER_BLK; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            asm_next[BLK_W-1-k*WORD_W -: WORD_W] = word_in;
         end
      end
   end

   // Assembly and one-deep output register; a load on the final beat wins over a drain in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         asm_q     <= '0;
         blk_data  <= '0;
         blk_last  <= 1'b0;
         blk_valid <= 1'b0;
         frame_err <= 1'b0;
         blk_cnt   <= '0;
      end else begin
         frame_err <= early_last;
         if (beat && !final_beat && !s_axis_tlast) begin
            asm_q <= asm_next;
         end
         if (final_beat) begin
            blk_data  <= asm_next;
            blk_last  <= s_axis_tlast;
            blk_valid <= 1'b1;
         end else if (drain) begin
            blk_valid <= 1'b0;
         end
         if (drain) begin
            blk_cnt <= blk_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_aes_axis_blk_rx.sv
// Self-checking bench for aes_axis_blk_rx: directed steps, negedge monitor with a scoreboard of expected blocks.
// Honours AES_AXIS_RX_BSWAP_EN when building expected words.
module tb_aes_axis_blk_rx;

   typedef struct {
      logic [127:0] data;
      logic         last;
   } blk_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  s_axis_tdata = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic         s_axis_tlast = 1'b0;
   logic [127:0] blk_data;
   logic         blk_last;
   logic         blk_valid;
   logic         blk_ready = 1'b1;
   logic         frame_err;
   logic [31:0]  blk_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   blk_t         sb_q[$];
   int           wcnt = 0;
   logic [95:0]  acc = '0;
   logic         ferr_exp = 1'b0;
   logic [31:0]  exp_cnt = '0;
   logic         rise_chk = 1'b0;
   logic         hold_chk = 1'b0;
   logic [127:0] prev_data = '0;
   logic         prev_last = 1'b0;
   int           blocks_seen = 0;
   int           lasts_seen = 0;

   aes_axis_blk_rx dut (
      .clock         (clock),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .blk_data      (blk_data),
      .blk_last      (blk_last),
      .blk_valid     (blk_valid),
      .blk_ready     (blk_ready),
      .frame_err     (frame_err),
      .blk_cnt       (blk_cnt)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input logic [31:0] d);
`ifdef AES_AXIS_RX_BSWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   // Monitor: checks the state produced by the last edge, then predicts the next edge from the sampled handshakes.
   always @(negedge clock) begin
      logic [31:0] w;
      blk_t        e;
      if (reset) begin
         sb_q.delete();
         wcnt        = 0;
         ferr_exp    = 1'b0;
         exp_cnt     = '0;
         rise_chk    = 1'b0;
         hold_chk    = 1'b0;
         blocks_seen = 0;
         lasts_seen  = 0;
      end else begin
         check("tready", s_axis_tready, !blk_valid || blk_ready);
         check("frame_err", frame_err, ferr_exp);
         check("blk_cnt", blk_cnt, exp_cnt);
         if (rise_chk) check("valid_latency", blk_valid, 1'b1);
         if (hold_chk) begin
            check("hold_valid", blk_valid, 1'b1);
            check("hold_data", blk_data, prev_data);
            check("hold_last", blk_last, prev_last);
         end
         hold_chk  = blk_valid && !blk_ready;
         prev_data = blk_data;
         prev_last = blk_last;
         if (blk_valid && blk_ready) begin
            if (sb_q.size() == 0) begin
               check("blk_unexpected", blk_valid, 1'b0);
            end else begin
               e = sb_q.pop_front();
               check("blk_data", blk_data, e.data);
               check("blk_last", blk_last, e.last);
            end
            exp_cnt = exp_cnt + 32'd1;
            blocks_seen++;
            if (blk_last) lasts_seen++;
         end
         rise_chk = 1'b0;
         ferr_exp = 1'b0;
         if (s_axis_tvalid && s_axis_tready) begin
            w = model_word(s_axis_tdata);
            if (wcnt == 3) begin
               e.data = {acc, w};
               e.last = s_axis_tlast;
               sb_q.push_back(e);
               wcnt     = 0;
               rise_chk = 1'b1;
            end else if (s_axis_tlast) begin
               wcnt     = 0;
               ferr_exp = 1'b1;
            end else begin
               acc = {acc[63:0], w};
               wcnt++;
            end
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = l;
      @(negedge clock);
      while (!s_axis_tready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!s_axis_tready) begin
         check("send_timeout", s_axis_tready, 1'b1);
      end else begin
         @(posedge clock);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || blk_valid) && n < 100) begin
         @(posedge clock);
         n++;
      end
      #1;
      check("drain_timeout", blk_valid, 1'b0);
   endtask

   task automatic apply_reset();
      reset         = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_tready", s_axis_tready, 1'b0);
      check("rst_valid", blk_valid, 1'b0);
      check("rst_data", blk_data, 128'd0);
      check("rst_last", blk_last, 1'b0);
      check("rst_ferr", frame_err, 1'b0);
      check("rst_cnt", blk_cnt, 32'd0);
      reset = 1'b0;
      #1;
      check("rst_tready_after", s_axis_tready, 1'b1);
   endtask

   initial begin
      logic [127:0] exp_blk;
      int           c0;

      // Basic block: four words, TLAST on the fourth.
      apply_reset();
      blk_ready = 1'b1;
      send_word(32'h33221100, 1'b0);
      send_word(32'h77665544, 1'b0);
      send_word(32'hBBAA9988, 1'b0);
      send_word(32'hFFEEDDCC, 1'b1);
`ifdef AES_AXIS_RX_BSWAP_EN
      exp_blk = 128'h00112233445566778899AABBCCDDEEFF;
`else
      exp_blk = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
`endif
      check("t1_valid", blk_valid, 1'b1);
      check("t1_data", blk_data, exp_blk);
      check("t1_last", blk_last, 1'b1);
      check("t1_cnt_before", blk_cnt, 32'd0);
      @(posedge clock);
      #1;
      check("t1_cnt_after", blk_cnt, 32'd1);
      wait_idle();

      // Backpressure: two blocks streamed while blk_ready is low.
      apply_reset();
      blk_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) send_word(32'h10 + 32'(i), i == 7);
         end
         begin
            repeat (12) @(posedge clock);
            #1;
            check("t3_tready_low", s_axis_tready, 1'b0);
            check("t3_valid_held", blk_valid, 1'b1);
            check("t3_blk1", blk_data, {model_word(32'h10), model_word(32'h11),
                                         model_word(32'h12), model_word(32'h13)});
            blk_ready = 1'b1;
         end
      join
      wait_idle();
      check("t3_cnt", blk_cnt, 32'd2);
      check("t3_blocks", 32'(blocks_seen), 32'd2);

      // Framing error: short message, then a clean block.
      apply_reset();
      send_word(32'h01, 1'b0);
      send_word(32'h02, 1'b1);
      check("t4_ferr_pulse", frame_err, 1'b1);
      send_word(32'h0A0B0C0D, 1'b0);
      check("t4_ferr_clear", frame_err, 1'b0);
      send_word(32'h1A1B1C1D, 1'b0);
      send_word(32'h2A2B2C2D, 1'b0);
      send_word(32'h3A3B3C3D, 1'b1);
      wait_idle();
      check("t4_blocks", 32'(blocks_seen), 32'd1);
      check("t4_cnt", blk_cnt, 32'd1);

      // Reset mid-block discards the partial words.
      apply_reset();
      for (int i = 0; i < 3; i++) send_word(32'h100 + 32'(i), 1'b0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) send_word(32'hA + 32'(i), i == 3);
      wait_idle();
      check("t5_blocks", 32'(blocks_seen), 32'd1);
      check("t5_cnt", blk_cnt, 32'd1);

      // Throughput: 16 words back-to-back, then 16 more with a 2-cycle source gap every 6 words.
      apply_reset();
      c0 = cyc;
      for (int i = 0; i < 16; i++) send_word($urandom, i == 15);
      check("t6_cycles", 32'(cyc - c0), 32'd16);
      wait_idle();
      check("t6_cnt", blk_cnt, 32'd4);
      check("t6_lasts", 32'(lasts_seen), 32'd1);
      for (int i = 0; i < 16; i++) begin
         if (i > 0 && i % 6 == 0) begin
            repeat (2) @(posedge clock);
            #1;
         end
         send_word($urandom, i == 15);
      end
      wait_idle();
      check("t6_cnt2", blk_cnt, 32'd8);
      check("t6_lasts2", 32'(lasts_seen), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
